// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU definitions: MULT/DIV sequencer state encoding and width
package cpu_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2,
    MD_FIN  = 2'd3
  } mdState_t;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one iteration of Booth radix-2 multiply or restoring divide
module muldiv_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             isDiv,
  input  logic [WIDTH:0]   accIn,
  input  logic [WIDTH-1:0] lowIn,
  input  logic             qm1In,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH:0]   accOut,
  output logic [WIDTH-1:0] lowOut,
  output logic             qm1Out
);

  logic [WIDTH:0] mcandExt;
  logic [WIDTH:0] boothSum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // acc is one bit wider than the operands so subtracting the most negative
  // multiplicand, or trial-subtracting a 2^(WIDTH-1) divisor, cannot overflow
  always_comb begin
    accOut   = accIn;
    lowOut   = lowIn;
    qm1Out   = qm1In;
    mcandExt = {operand[WIDTH-1], operand};
    boothSum = accIn;
    shifted  = {accIn[WIDTH-1:0], lowIn[WIDTH-1]};
    trial    = shifted - {1'b0, operand};
    if (isDiv) begin
      qm1Out = 1'b0;
      if (trial[WIDTH]) begin
        accOut = shifted;
        lowOut = {lowIn[WIDTH-2:0], 1'b0};
      end else begin
        accOut = trial;
        lowOut = {lowIn[WIDTH-2:0], 1'b1};
      end
    end else begin
      case ({lowIn[0], qm1In})
        2'b01:   boothSum = accIn + mcandExt;
        2'b10:   boothSum = accIn - mcandExt;
        default: boothSum = accIn;
      endcase
      accOut = {boothSum[WIDTH], boothSum[WIDTH:1]};
      lowOut = {boothSum[0], lowIn[WIDTH-1:1]};
      qm1Out = lowIn[0];
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multicycle MULT/DIV controller owning the HI/LO registers
module muldiv_sequencer
  import cpu_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_req,
  input  logic             div_req,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  mdState_t         state, stateNext;
  logic [5:0]       count;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] low;
  logic             qm1;
  logic [WIDTH-1:0] operand;
  logic             isDiv, negQ, negR;

  logic             acceptMult, acceptDiv, flagZero;
  logic [WIDTH:0]   stepAcc;
  logic [WIDTH-1:0] stepLow;
  logic             stepQm1;
  logic [WIDTH-1:0] aMag, bMag, quotFix, remFix;

  assign aMag    = op_a[WIDTH-1] ? -op_a : op_a;
  assign bMag    = op_b[WIDTH-1] ? -op_b : op_b;
  assign quotFix = negQ ? -low : low;
  assign remFix  = negR ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

  muldiv_step #(.WIDTH(WIDTH)) stepUnit (
    .isDiv   (isDiv),
    .accIn   (acc),
    .lowIn   (low),
    .qm1In   (qm1),
    .operand (operand),
    .accOut  (stepAcc),
    .lowOut  (stepLow),
    .qm1Out  (stepQm1)
  );

  always_comb begin
    stateNext  = state;
    acceptMult = 1'b0;
    acceptDiv  = 1'b0;
    flagZero   = 1'b0;
    case (state)
      MD_IDLE: begin
        if (mult_req) begin
          acceptMult = 1'b1;
          stateNext  = MD_MULT;
        end else if (div_req) begin
          if (op_b == '0) begin
            flagZero = 1'b1;
          end else begin
            acceptDiv = 1'b1;
            stateNext = MD_DIV;
          end
        end
      end
      MD_MULT, MD_DIV: if (count == LAST_STEP) stateNext = MD_FIN;
      MD_FIN:          stateNext = MD_IDLE;
      default:         stateNext = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= MD_IDLE;
      count    <= '0;
      acc      <= '0;
      low      <= '0;
      qm1      <= 1'b0;
      operand  <= '0;
      isDiv    <= 1'b0;
      negQ     <= 1'b0;
      negR     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state    <= stateNext;
      busy     <= (stateNext != MD_IDLE);
      done     <= (state == MD_FIN);
      div_zero <= flagZero;
      if (acceptMult) begin
        acc     <= '0;
        low     <= op_b;
        qm1     <= 1'b0;
        operand <= op_a;
        isDiv   <= 1'b0;
        count   <= '0;
      end else if (acceptDiv) begin
        // divide runs on magnitudes; signs are remembered for the FIN fix-up
        acc     <= '0;
        low     <= aMag;
        qm1     <= 1'b0;
        operand <= bMag;
        isDiv   <= 1'b1;
        negQ    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
        negR    <= op_a[WIDTH-1];
        count   <= '0;
      end else if (state == MD_MULT || state == MD_DIV) begin
        acc   <= stepAcc;
        low   <= stepLow;
        qm1   <= stepQm1;
        count <= count + 6'd1;
      end
      if (state == MD_FIN) begin
        hi <= isDiv ? remFix : acc[WIDTH-1:0];
        lo <= isDiv ? quotFix : low;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer with a behavioural model
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mult_req = 1'b0;
  logic        div_req = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (rst),
    .mult_req (mult_req),
    .div_req  (div_req),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mulRef(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  function automatic logic [63:0] divRef(input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    x = longint'($signed(a));
    y = longint'($signed(b));
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Model: an accepted op finishes 33 edges later; HI/LO only change then
  int          remain;
  logic [63:0] pend;
  logic        eBusy, eDone, eDz;
  logic [31:0] eHi, eLo;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      remain = 0; pend = '0;
      eBusy = 0; eDone = 0; eDz = 0; eHi = '0; eLo = '0;
    end else begin
      eDone = 0;
      eDz   = 0;
      if (remain == 0) begin
        if (mult_req) begin
          pend = mulRef(op_a, op_b);
          remain = 33;
        end else if (div_req) begin
          if (op_b == 32'd0) eDz = 1;
          else begin
            pend = divRef(op_a, op_b);
            remain = 33;
          end
        end
      end else begin
        remain--;
        if (remain == 0) begin
          {eHi, eLo} = pend;
          eDone = 1;
        end
      end
      eBusy = (remain != 0);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if ({busy, done, div_zero, hi, lo} !== {eBusy, eDone, eDz, eHi, eLo}) begin
        fails++;
        $display("FAIL cycle_check t=%0t got busy=%b done=%b dz=%b hi=%h lo=%h required busy=%b done=%b dz=%b hi=%h lo=%h",
                 $time, busy, done, div_zero, hi, lo, eBusy, eDone, eDz, eHi, eLo);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // n counts negedges after the drive; negedge n follows accept edge + (n-1)
  task automatic runOp(input string name, input bit m, input bit d,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] xHi, input logic [31:0] xLo, input bit disturb);
    int n;
    int busyCnt;
    bit seen;
    @(negedge clk);
    mult_req = m; div_req = d; op_a = a; op_b = b;
    n = 0; busyCnt = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin mult_req = 0; div_req = 0; end
      if (disturb && n == 3) op_a = ~a;
      if (disturb && n == 5) begin mult_req = 1; div_req = 1; op_b = 32'd1; end
      if (disturb && n == 6) begin mult_req = 0; div_req = 0; end
      if (busy) busyCnt++;
      if (done) seen = 1;
    end
    chk({name, " latency"}, 64'(n - 1), 64'd33);
    chk({name, " busy_cycles"}, 64'(busyCnt), 64'd33);
    chk({name, " hi"}, {32'd0, hi}, {32'd0, xHi});
    chk({name, " lo"}, {32'd0, lo}, {32'd0, xLo});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($signed($urandom_range(0, 40)) - 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state", {28'd0, busy, done, div_zero, 1'b0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    rst = 0;

    runOp("mul_7_m3", 1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    runOp("mul_max", 1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 0);
    runOp("div_m7_2", 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    runOp("div_7_m2", 0, 1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
    runOp("div_preset", 0, 1, 32'h451, 32'h20, 32'h11, 32'h22, 0);

    @(negedge clk);
    div_req = 1; op_a = 32'd5; op_b = 32'd0;
    @(negedge clk);
    div_req = 0;
    chk("divzero_pulse", {62'd0, div_zero, busy}, 64'b10);
    @(negedge clk);
    chk("divzero_after", {62'd0, div_zero, done}, 64'd0);
    chk("divzero_hilo", {hi, lo}, {32'h11, 32'h22});

    runOp("div_ovf", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0);
    runOp("both_req", 1, 1, 32'd6, 32'd5, 32'd0, 32'd30, 1);

    @(negedge clk);
    mult_req = 1; op_a = 32'h12345; op_b = 32'h777;
    @(negedge clk);
    mult_req = 0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1 chk("reset_mid", {31'd0, busy, hi}, 64'd0);
    chk("reset_mid_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst = 0;
    chk("reset_no_done", {63'd0, done}, 64'd0);
    runOp("mul_3_4", 1, 0, 32'd3, 32'd4, 32'd0, 32'd12, 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      mult_req = ($urandom_range(0, 5) == 0);
      div_req  = ($urandom_range(0, 4) == 0);
      op_a = pick();
      op_b = pick();
    end
    @(negedge clk);
    mult_req = 0; div_req = 0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
